// File: rtl/gf_pkg.sv
// Shared GF(2^m) constants, inverter FSM encoding and a width-generic squaring helper
// used on the operand-load path of the iterative inverter.
package gf_pkg;

    localparam logic [7:0]  AES_POLY      = 8'h1B;
    localparam logic [3:0]  SUBFIELD_POLY = 4'h3;
    localparam int unsigned GF_MAX_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } inv_state_e;

    // Shift-and-add multiply over GF(2^m), m <= GF_MAX_W; operands live in the low m bits.
    function automatic logic [GF_MAX_W-1:0] gf_mul(
        input logic [GF_MAX_W-1:0] a,
        input logic [GF_MAX_W-1:0] b,
        input int unsigned         m,
        input logic [GF_MAX_W-1:0] poly
    );
        logic [GF_MAX_W-1:0] acc;
        logic [GF_MAX_W-1:0] sh;
        logic [GF_MAX_W-1:0] bs;
        logic [GF_MAX_W-1:0] mask;
        logic [GF_MAX_W-1:0] msb;
        mask = GF_MAX_W'((17'(1) << m) - 17'(1));
        msb  = GF_MAX_W'(17'(1) << (m - 1));
        acc  = '0;
        sh   = a & mask;
        bs   = b & mask;
        for (int i = 0; i < int'(GF_MAX_W); i++) begin
            if (bs[0]) begin
                acc = acc ^ sh;
            end
            if ((sh & msb) != '0) begin
                sh = ((sh << 1) ^ poly) & mask;
            end else begin
                sh = (sh << 1) & mask;
            end
            bs = bs >> 1;
        end
        return acc;
    endfunction

    function automatic logic [GF_MAX_W-1:0] gf_sq(
        input logic [GF_MAX_W-1:0] x,
        input int unsigned         m,
        input logic [GF_MAX_W-1:0] poly
    );
        return gf_mul(x, x, m, poly);
    endfunction

endpackage

// File: rtl/gf2m_mul.sv
// Combinational GF(2^M) multiplier, reduction by x^M + POLY folded into each shift step.
module gf2m_mul #(
    parameter int unsigned  M    = 8,
    parameter logic [M-1:0] POLY = M'(8'h1B)
) (
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    output logic [M-1:0] prod_o
);

    logic [M-1:0] acc;
    logic [M-1:0] sh;
    logic [M-1:0] bs;

    always_comb begin
        acc = '0;
        sh  = a_i;
        bs  = b_i;
        for (int i = 0; i < int'(M); i++) begin
            if (bs[0]) begin
                acc = acc ^ sh;
            end
            sh = sh[M-1] ? ((sh << 1) ^ POLY) : (sh << 1);
            bs = bs >> 1;
        end
        prod_o = acc;
    end

endmodule

// File: rtl/gf2m_inv_iter.sv
// Iterative GF(2^M) inverter: a^(2^M-2) built as a^2 * a^4 * ... * a^(2^(M-1)),
// one square and one multiply per cycle, inv(0)=0, valid/ready on both sides.
module gf2m_inv_iter
    import gf_pkg::*;
#(
    parameter int unsigned  M     = 8,
    parameter logic [M-1:0] POLY  = M'(AES_POLY),
    parameter int unsigned  TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W = (M > 2) ? $clog2(M) : 1;

    inv_state_e         state_q, state_d;
    logic [M-1:0]       t_q, t_d;
    logic [M-1:0]       r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               out_valid_q, out_valid_d;
    logic               rdy_c;
    logic [M-1:0]       sq_in;
    logic [M-1:0]       sq_t;
    logic [M-1:0]       mul_r;

    assign sq_in = M'(gf_sq(GF_MAX_W'(in_data), M, GF_MAX_W'(POLY)));
    assign sq_t  = M'(gf_sq(GF_MAX_W'(t_q), M, GF_MAX_W'(POLY)));

    gf2m_mul #(
        .M    (M),
        .POLY (POLY)
    ) u_mul (
        .a_i    (r_q),
        .b_i    (sq_t),
        .prod_o (mul_r)
    );

    // Next-state, datapath update and handshake decode.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        rdy_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                rdy_c = 1'b1;
                if (in_valid) begin
                    t_d     = sq_in;
                    r_d     = sq_in;
                    tag_d   = in_tag;
                    cnt_d   = CNT_W'(M - 2);
                    state_d = (M == 2) ? DONE : CALC;
                end
            end
            CALC: begin
                t_d   = sq_t;
                r_d   = mul_r;
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Result hand-off and next operand load share one edge.
                rdy_c = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        t_d     = sq_in;
                        r_d     = sq_in;
                        tag_d   = in_tag;
                        cnt_d   = CNT_W'(M - 2);
                        state_d = (M == 2) ? DONE : CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = rdy_c & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = r_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_gf2m_inv_iter.sv
// Directed bench for gf2m_inv_iter at M=8 (AES), M=4 (subfield) and M=2.
module tb_gf2m_inv_iter;

    logic clk = 1'b0;
    logic rst;

    logic       iv8, ir8, ov8, or8;
    logic [7:0] id8, od8;
    logic [3:0] it8, ot8;

    logic       iv4, ir4, ov4, or4;
    logic [3:0] id4, od4;
    logic [3:0] it4, ot4;

    logic       iv2, ir2, ov2, or2;
    logic [1:0] id2, od2;
    logic [3:0] it2, ot2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gf2m_inv_iter #(.M(8), .POLY(8'h1B), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_tag(it8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_tag(ot8)
    );

    gf2m_inv_iter #(.M(4), .POLY(gf_pkg::SUBFIELD_POLY), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_tag(it4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_tag(ot4)
    );

    gf2m_inv_iter #(.M(2), .POLY(2'h3), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_tag(it2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_tag(ot2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference AES-field multiply, x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Present an operand until accepted, then count cycles (accept cycle = 0) until out_valid.
    task automatic issue8(input logic [7:0] a, input logic [3:0] tg, input string nm, output int lat);
        int n;
        @(negedge clk);
        iv8 = 1'b1; id8 = a; it8 = tg;
        #1;
        n = 0;
        while (!ir8 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk({nm, "_accept"}, 32'(ir8), 32'h1);
        lat = 0;
        do begin
            @(negedge clk); iv8 = 1'b0; lat++;
        end while (!ov8 && lat < 50);
    endtask

    task automatic pop8(input string nm);
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk({nm, "_popped"}, 32'(ov8), 32'h0);
    endtask

    task automatic xact8(input logic [7:0] a, input logic [3:0] tg, input logic [7:0] exp, input string nm);
        int lat;
        issue8(a, tg, nm, lat);
        chk({nm, "_lat"},  32'(lat), 32'd7);
        chk({nm, "_data"}, 32'(od8), 32'(exp));
        chk({nm, "_tag"},  32'(ot8), 32'(tg));
        pop8(nm);
    endtask

    task automatic xact4(input logic [3:0] a, input logic [3:0] exp, input string nm);
        int n;
        @(negedge clk);
        iv4 = 1'b1; id4 = a; it4 = 4'hA;
        #1;
        chk({nm, "_accept"}, 32'(ir4), 32'h1);
        n = 0;
        do begin
            @(negedge clk); iv4 = 1'b0; n++;
        end while (!ov4 && n < 50);
        chk({nm, "_lat"},  32'(n), 32'd3);
        chk({nm, "_data"}, 32'(od4), 32'(exp));
        chk({nm, "_tag"},  32'(ot4), 32'hA);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk({nm, "_popped"}, 32'(ov4), 32'h0);
    endtask

    task automatic xact2(input logic [1:0] a, input logic [1:0] exp, input string nm);
        int n;
        @(negedge clk);
        iv2 = 1'b1; id2 = a; it2 = 4'h5;
        #1;
        chk({nm, "_accept"}, 32'(ir2), 32'h1);
        n = 0;
        do begin
            @(negedge clk); iv2 = 1'b0; n++;
        end while (!ov2 && n < 50);
        chk({nm, "_lat"},  32'(n), 32'd1);
        chk({nm, "_data"}, 32'(od2), 32'(exp));
        chk({nm, "_tag"},  32'(ot2), 32'h5);
        or2 = 1'b1;
        @(negedge clk);
        or2 = 1'b0;
        chk({nm, "_popped"}, 32'(ov2), 32'h0);
    endtask

    // Continuous producer/consumer: operands base+i, tags i; checks a*inv(a)=1, tag order, spacing.
    task automatic stream8(input int n, input logic [7:0] base, input string nm);
        logic [7:0] q_a[$];
        logic [3:0] q_t[$];
        logic [7:0] ea;
        logic [3:0] et;
        int sent, got, cyc, last;
        bit acc;
        sent = 0; got = 0; cyc = 0; last = -1;
        @(negedge clk);
        or8 = 1'b1; iv8 = 1'b1; id8 = base; it8 = 4'h0;
        while (got < n && cyc < 4000) begin
            #1;
            if (ov8) begin
                if (q_a.size() == 0) begin
                    chk({nm, "_extra_result"}, 32'h1, 32'h0);
                end else begin
                    ea = q_a.pop_front();
                    et = q_t.pop_front();
                    if (ea == 8'h00) chk({nm, "_zero"}, 32'(od8), 32'h0);
                    else             chk({nm, "_prod"}, 32'(ref_mul8(ea, od8)), 32'h1);
                    chk({nm, "_tag"}, 32'(ot8), 32'(et));
                    if (last >= 0) chk({nm, "_period"}, 32'(cyc - last), 32'd7);
                end
                last = cyc;
                got++;
            end
            acc = iv8 && ir8;
            if (acc) begin
                q_a.push_back(id8);
                q_t.push_back(it8);
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                sent++;
                if (sent < n) begin
                    id8 = 8'(int'(base) + sent);
                    it8 = 4'(sent);
                end else begin
                    iv8 = 1'b0;
                end
            end
        end
        chk({nm, "_count"}, 32'(got), 32'(n));
        or8 = 1'b0;
        iv8 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  stale;
        bit  held;

        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; id8 = '0; it8 = '0;
        iv4 = 1'b0; or4 = 1'b0; id4 = '0; it4 = '0;
        iv2 = 1'b0; or2 = 1'b0; id2 = '0; it2 = '0;

        #2;
        chk("rst_in_ready",  32'(ir8), 32'h0);
        chk("rst_out_valid", 32'(ov8), 32'h0);
        chk("rst_out_data",  32'(od8), 32'h0);
        chk("rst_out_tag",   32'(ot8), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready8", 32'(ir8), 32'h1);
        chk("rel_in_ready4", 32'(ir4), 32'h1);
        chk("rel_in_ready2", 32'(ir2), 32'h1);

        // AES field known inverses and the two boundary operands.
        xact8(8'h53, 4'h1, 8'hCA, "aes53");
        xact8(8'h02, 4'h2, 8'h8D, "aes02");
        xact8(8'hFF, 4'h3, 8'h1C, "aesFF");
        xact8(8'h00, 4'h4, 8'h00, "aes00");
        xact8(8'h01, 4'h5, 8'h01, "aes01");

        // Small fields.
        xact4(4'h2, 4'h9, "gf16_2");
        xact4(4'h9, 4'h2, "gf16_9");
        xact4(4'h0, 4'h0, "gf16_0");
        xact2(2'h2, 2'h3, "gf4_2");

        // Backpressure: result frozen, in_ready low, then hand-off and new accept on one edge.
        issue8(8'h53, 4'h5, "bp", lat);
        chk("bp_data0", 32'(od8), 32'hCA);
        iv8 = 1'b1; id8 = 8'h02; it8 = 4'h6;
        held = 1'b1;
        repeat (10) begin
            @(negedge clk); #1;
            if (!(ov8 === 1'b1 && od8 === 8'hCA && ot8 === 4'h5 && ir8 === 1'b0)) held = 1'b0;
        end
        chk("bp_hold", 32'(held), 32'h1);
        or8 = 1'b1;
        #1;
        chk("bp_same_edge_ready", 32'(ir8), 32'h1);
        @(negedge clk);
        or8 = 1'b0; iv8 = 1'b0;
        chk("bp_consumed", 32'(ov8), 32'h0);
        lat = 1;
        while (!ov8 && lat < 50) begin
            @(negedge clk); lat++;
        end
        chk("bp_lat",  32'(lat), 32'd7);
        chk("bp_data", 32'(od8), 32'h8D);
        chk("bp_tag",  32'(ot8), 32'h6);
        pop8("bp");

        // Back-to-back traffic, then the full operand sweep.
        stream8(16, 8'hA0, "b2b");
        stream8(256, 8'h00, "sweep");

        // Reset during CALC, with a producer pushing while busy.
        @(negedge clk);
        iv8 = 1'b1; id8 = 8'h53; it8 = 4'h9;
        #1;
        chk("rst_mid_accept", 32'(ir8), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            id8 = 8'hFF; it8 = 4'h1;
            #1;
            chk("calc_ignore", 32'(ir8), 32'h0);
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(ov8), 32'h0);
        chk("rst_mid_data",  32'(od8), 32'h0);
        chk("rst_mid_tag",   32'(ot8), 32'h0);
        chk("rst_mid_ready", 32'(ir8), 32'h0);
        iv8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rel_ready", 32'(ir8), 32'h1);
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ov8 !== 1'b0) stale = 1'b1;
        end
        chk("rst_no_stale", 32'(stale), 32'h0);
        xact8(8'h53, 4'h3, 8'hCA, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
